// File: rtl/mqc_pkg.sv
// Shared types for the LTE-side capture sequencer: FSM states, the
// telemetry header word layout and the telemetry frame-length helper.
// No ports; imported by mqc_capture_seq and mqc_next_ch.
package mqc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TLM   = 2'd1,
    S_IQ    = 2'd2,
    S_READY = 2'd3
  } state_t;

  // Low 32 bits of a telemetry header word; upper buffer bits are zero.
  typedef struct packed {
    logic [15:0] magic;  // [31:16]
    logic [7:0]  seq;    // [15:8]
    logic [7:0]  chan;   // [7:0]
  } hdr_t;

  localparam int unsigned MAX_CH = 256;

  // Words in a telemetry frame: every enabled channel gives seg_len data
  // words plus one header word. Mask is zero-padded up to 256 channels.
  function automatic logic [31:0] f_tlm_len(input logic [MAX_CH-1:0] mask,
                                            input int unsigned seg_len);
    int unsigned n;
    n = 0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (mask[k]) n++;
    end
    return 32'(n * (seg_len + 1));
  endfunction

endpackage

// File: rtl/mqc_next_ch.sv
// Combinational priority finder: lowest set mask bit above cur_i (or the
// lowest set bit overall when first_i), plus a flag when none remains.
// Latency 0; no backpressure. Ports: mask_i, cur_i, first_i -> nxt_o, last_o.
module mqc_next_ch import mqc_pkg::*; #(
  parameter int pCH_NUM = 17,
  parameter int CH_W    = (pCH_NUM > 1) ? $clog2(pCH_NUM) : 1
) (
  input  logic [pCH_NUM-1:0] mask_i,
  input  logic [CH_W-1:0]    cur_i,
  input  logic               first_i,
  output logic [CH_W-1:0]    nxt_o,
  output logic               last_o
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    nxt_o  = '0;
    last_o = 1'b1;
    for (int k = pCH_NUM - 1; k >= 0; k--) begin
      if (mask_i[k] && (first_i || (k > int'(cur_i)))) begin
        nxt_o  = CH_W'(k);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mqc_capture_seq.sv
// Capture sequencer: builds telemetry frames (per-channel segments + header)
// or IQ captures into the buffer write port, then holds the frame for the reader.
// Latency: one write per accepted ivalid, issued the following cycle.
// Backpressure: none on the write port; a held frame blocks capture until ird_done.
// Ports: iclk_lte/ireset; ienable, ivalid, itrig_iq, idata_re/im, ich_data,
//        ich_mask, ird_done in; owr_en/addr/data, obuf_ready/mode/len, oseq out.
module mqc_capture_seq import mqc_pkg::*; #(
  parameter int          pDAT_W   = 32,
  parameter int          pIQ_W    = 12,
  parameter int          pCH_NUM  = 17,
  parameter int          pSEG_LEN = 1023,
  parameter int          pIQ_NUM  = 200000,
  parameter int          pADDR_W  = 18,
  parameter logic [15:0] pMAGIC   = 16'hAFA
) (
  input  logic                        iclk_lte,
  input  logic                        ireset,
  input  logic                        ienable,
  input  logic                        ivalid,
  input  logic                        itrig_iq,
  input  logic [pIQ_W-1:0]            idata_re,
  input  logic [pIQ_W-1:0]            idata_im,
  input  logic [pCH_NUM*pDAT_W-1:0]   ich_data,
  input  logic [pCH_NUM-1:0]          ich_mask,
  input  logic                        ird_done,
  output logic                        owr_en,
  output logic [pADDR_W-1:0]          owr_addr,
  output logic [pDAT_W-1:0]           owr_data,
  output logic                        obuf_ready,
  output logic                        obuf_mode,
  output logic [pADDR_W:0]            obuf_len,
  output logic [7:0]                  oseq
);

  localparam int CH_W  = (pCH_NUM > 1) ? $clog2(pCH_NUM) : 1;
  localparam int SEG_W = $clog2(pSEG_LEN + 1);

  state_t               state_q, state_d;
  logic [pCH_NUM-1:0]   mask_q, mask_d;
  logic [pADDR_W-1:0]   addr_q, addr_d;
  logic [CH_W-1:0]      chan_q, chan_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic                 iq_pend_q, iq_pend_d;
  logic                 wr_en_q, wr_en_d;
  logic [pADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [pDAT_W-1:0]    wr_data_q, wr_data_d;
  logic                 buf_ready_q, buf_ready_d;
  logic                 buf_mode_q, buf_mode_d;
  logic [pADDR_W:0]     buf_len_q, buf_len_d;
  logic [7:0]           seq_q, seq_d;

  logic [pCH_NUM-1:0]   find_mask;
  logic [CH_W-1:0]      nxt_ch;
  logic                 last_ch;
  hdr_t                 hdr;
  logic [31:0]          iq_word;

  // In idle the finder looks at the live mask to pick the first channel;
  // during a frame it walks the mask latched at frame start.
  assign find_mask = (state_q == S_IDLE) ? ich_mask : mask_q;

  mqc_next_ch #(
    .pCH_NUM (pCH_NUM),
    .CH_W    (CH_W)
  ) u_next_ch (
    .mask_i  (find_mask),
    .cur_i   (chan_q),
    .first_i (state_q == S_IDLE),
    .nxt_o   (nxt_ch),
    .last_o  (last_ch)
  );

  assign hdr     = '{magic: pMAGIC, seq: seq_q, chan: 8'(chan_q)};
  assign iq_word = {16'($signed(idata_re)), 16'($signed(idata_im))};

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    chan_d      = chan_q;
    seg_d       = seg_q;
    iq_pend_d   = iq_pend_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    buf_ready_d = buf_ready_q;
    buf_mode_d  = buf_mode_q;
    buf_len_d   = buf_len_q;
    seq_d       = seq_q;

    case (state_q)
      S_IDLE: begin
        if (itrig_iq || iq_pend_q) begin
          state_d   = S_IQ;
          iq_pend_d = 1'b0;
          addr_d    = '0;
        end else if (ienable && (|ich_mask)) begin
          state_d = S_TLM;
          mask_d  = ich_mask;
          addr_d  = '0;
          chan_d  = nxt_ch;
          seg_d   = '0;
        end
      end

      S_TLM: begin
        // IQ request wins: the partial frame is dropped without a header.
        if (itrig_iq) begin
          state_d = S_IQ;
          addr_d  = '0;
        end else if (ivalid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          addr_d    = addr_q + pADDR_W'(1);
          if (seg_q != SEG_W'(pSEG_LEN)) begin
            wr_data_d = ich_data[int'(chan_q)*pDAT_W +: pDAT_W];
            seg_d     = seg_q + SEG_W'(1);
          end else begin
            wr_data_d = pDAT_W'(hdr);
            seg_d     = '0;
            chan_d    = nxt_ch;
            if (last_ch) begin
              buf_len_d   = {1'b0, addr_q} + (pADDR_W+1)'(1);
              buf_mode_d  = 1'b0;
              buf_ready_d = 1'b1;
              state_d     = S_READY;
            end
          end
        end
      end

      S_IQ: begin
        if (ivalid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = pDAT_W'(iq_word);
          addr_d    = addr_q + pADDR_W'(1);
          if (addr_q == pADDR_W'(pIQ_NUM - 1)) begin
            buf_len_d   = (pADDR_W+1)'(pIQ_NUM);
            buf_mode_d  = 1'b1;
            buf_ready_d = 1'b1;
            state_d     = S_READY;
          end
        end
      end

      S_READY: begin
        if (ird_done) begin
          buf_ready_d = 1'b0;
          if (!buf_mode_q) seq_d = seq_q + 8'd1;
          // A trigger arriving with the release skips the idle cycle.
          if (itrig_iq) begin
            state_d   = S_IQ;
            iq_pend_d = 1'b0;
            addr_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (itrig_iq) begin
          iq_pend_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk_lte or negedge ireset) begin
    if (!ireset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      addr_q      <= '0;
      chan_q      <= '0;
      seg_q       <= '0;
      iq_pend_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      buf_ready_q <= 1'b0;
      buf_mode_q  <= 1'b0;
      buf_len_q   <= '0;
      seq_q       <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      chan_q      <= chan_d;
      seg_q       <= seg_d;
      iq_pend_q   <= iq_pend_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      buf_ready_q <= buf_ready_d;
      buf_mode_q  <= buf_mode_d;
      buf_len_q   <= buf_len_d;
      seq_q       <= seq_d;
    end
  end

  assign owr_en     = wr_en_q;
  assign owr_addr   = wr_addr_q;
  assign owr_data   = wr_data_q;
  assign obuf_ready = buf_ready_q;
  assign obuf_mode  = buf_mode_q;
  assign obuf_len   = buf_len_q;
  assign oseq       = seq_q;

endmodule

// File: tb/tb_mqc_capture_seq.sv
// Directed bench for mqc_capture_seq with 3 channels, 4-word segments, 8 IQ words.
// Inputs change 2 units after a rising edge; writes are logged on falling edges.
// Ports: none.
module tb_mqc_capture_seq;

  logic         iclk_lte = 1'b0;
  logic         ireset   = 1'b0;
  logic         ienable  = 1'b0;
  logic         ivalid   = 1'b0;
  logic         itrig_iq = 1'b0;
  logic [11:0]  idata_re = '0;
  logic [11:0]  idata_im = '0;
  logic [95:0]  ich_data = {32'h33333333, 32'h22222222, 32'h11111111};
  logic [2:0]   ich_mask = '0;
  logic         ird_done = 1'b0;
  logic         owr_en;
  logic [17:0]  owr_addr;
  logic [31:0]  owr_data;
  logic         obuf_ready;
  logic         obuf_mode;
  logic [18:0]  obuf_len;
  logic [7:0]   oseq;

  int nvec = 0;
  int nerr = 0;

  logic [17:0] q_addr[$];
  logic [31:0] q_data[$];
  time         q_t[$];

  mqc_capture_seq #(
    .pDAT_W(32), .pIQ_W(12), .pCH_NUM(3), .pSEG_LEN(4),
    .pIQ_NUM(8), .pADDR_W(18), .pMAGIC(16'hAFA)
  ) dut (
    .iclk_lte(iclk_lte), .ireset(ireset), .ienable(ienable), .ivalid(ivalid),
    .itrig_iq(itrig_iq), .idata_re(idata_re), .idata_im(idata_im),
    .ich_data(ich_data), .ich_mask(ich_mask), .ird_done(ird_done),
    .owr_en(owr_en), .owr_addr(owr_addr), .owr_data(owr_data),
    .obuf_ready(obuf_ready), .obuf_mode(obuf_mode), .obuf_len(obuf_len),
    .oseq(oseq)
  );

  always #5 iclk_lte = ~iclk_lte;

  always @(negedge iclk_lte) begin
    if (owr_en) begin
      q_addr.push_back(owr_addr);
      q_data.push_back(owr_data);
      q_t.push_back($time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_t.delete();
  endtask

  // Waits for obuf_ready (optionally toggling ivalid each cycle), then lets
  // the falling-edge logger catch the final write.
  task automatic wait_ready(input string tag, input int budget, input bit tog);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (tog) ivalid = ~ivalid;
      @(posedge iclk_lte); #2;
      if (obuf_ready) got = 1'b1;
    end
    @(negedge iclk_lte); #1;
    check_vec(tag, 64'(got), 64'd1);
  endtask

  task automatic pulse_done();
    ird_done = 1'b1;
    @(posedge iclk_lte); #2;
    ird_done = 1'b0;
  endtask

  task automatic pulse_trig();
    itrig_iq = 1'b1;
    @(posedge iclk_lte); #2;
    itrig_iq = 1'b0;
  endtask

  initial begin
    bit hit;
    // ---- reset state
    repeat (3) @(posedge iclk_lte);
    #2;
    check_vec("rst_wr", {owr_en, owr_addr, owr_data}, 64'd0);
    check_vec("rst_buf", {obuf_ready, obuf_mode, obuf_len, oseq}, 64'd0);
    ireset = 1'b1;
    @(posedge iclk_lte); #2;

    // ---- full telemetry frame, mask 111
    clear_log();
    ich_mask = 3'b111; ienable = 1'b1; ivalid = 1'b1;
    wait_ready("t1_ready", 100, 1'b0);
    ienable = 1'b0;
    check_vec("t1_count", 64'(q_addr.size()), 64'd15);
    for (int i = 0; i < 15; i++) check_vec($sformatf("t1_addr%0d", i), 64'(q_addr[i]), 64'(i));
    check_vec("t1_d0", 64'(q_data[0]), 64'h11111111);
    check_vec("t1_hdr4", 64'(q_data[4]), 64'h0AFA0000);
    check_vec("t1_d5", 64'(q_data[5]), 64'h22222222);
    check_vec("t1_hdr9", 64'(q_data[9]), 64'h0AFA0001);
    check_vec("t1_d13", 64'(q_data[13]), 64'h33333333);
    check_vec("t1_hdr14", 64'(q_data[14]), 64'h0AFA0002);
    check_vec("t1_len", 64'(obuf_len), 64'd15);
    check_vec("t1_mode", 64'(obuf_mode), 64'd0);
    check_vec("t1_seq_held", 64'(oseq), 64'd0);
    pulse_done();
    check_vec("t1_release", 64'(obuf_ready), 64'd0);
    check_vec("t1_seq", 64'(oseq), 64'd1);

    // ---- sparse mask 101, twice
    clear_log();
    ich_mask = 3'b101; ienable = 1'b1;
    wait_ready("t2_ready", 100, 1'b0);
    ienable = 1'b0;
    check_vec("t2_count", 64'(q_addr.size()), 64'd10);
    check_vec("t2_hdr4", 64'(q_data[4]), 64'h0AFA0100);
    check_vec("t2_d5", 64'(q_data[5]), 64'h33333333);
    check_vec("t2_hdr9", 64'(q_data[9]), 64'h0AFA0102);
    check_vec("t2_len", 64'(obuf_len), 64'd10);
    pulse_done();
    check_vec("t2_seq", 64'(oseq), 64'd2);
    clear_log();
    ienable = 1'b1;
    wait_ready("t2b_ready", 100, 1'b0);
    ienable = 1'b0;
    check_vec("t2b_hdr4", 64'(q_data[4]), 64'h0AFA0200);
    check_vec("t2b_addr9", 64'(q_addr[9]), 64'd9);
    pulse_done();
    check_vec("t2b_seq", 64'(oseq), 64'd3);

    // ---- IQ capture with ivalid toggling
    clear_log();
    idata_re = 12'hFFF; idata_im = 12'h005; ivalid = 1'b0;
    pulse_trig();
    wait_ready("t3_ready", 100, 1'b1);
    check_vec("t3_count", 64'(q_addr.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_vec($sformatf("t3_addr%0d", i), 64'(q_addr[i]), 64'(i));
      check_vec($sformatf("t3_data%0d", i), 64'(q_data[i]), 64'hFFFF0005);
    end
    check_vec("t3_gap", 64'(q_t[1] - q_t[0]), 64'd20);
    check_vec("t3_mode", 64'(obuf_mode), 64'd1);
    check_vec("t3_len", 64'(obuf_len), 64'd8);
    pulse_done();
    check_vec("t3_seq", 64'(oseq), 64'd3);

    // ---- IQ trigger aborts a telemetry frame at addr 6
    clear_log();
    ich_mask = 3'b111; ienable = 1'b1; ivalid = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge iclk_lte); #2;
      if (owr_en && owr_addr == 18'd5) hit = 1'b1;
    end
    check_vec("t4_reach5", 64'(hit), 64'd1);
    ienable = 1'b0;
    pulse_trig();
    wait_ready("t4_ready", 100, 1'b0);
    check_vec("t4_count", 64'(q_addr.size()), 64'd14);
    check_vec("t4_hdr4", 64'(q_data[4]), 64'h0AFA0300);
    check_vec("t4_addr5", 64'(q_addr[5]), 64'd5);
    check_vec("t4_iq_addr", 64'(q_addr[6]), 64'd0);
    check_vec("t4_iq_data", 64'(q_data[6]), 64'hFFFF0005);
    check_vec("t4_mode", 64'(obuf_mode), 64'd1);
    check_vec("t4_seq", 64'(oseq), 64'd3);

    // ---- trigger while held, release later starts IQ by itself
    clear_log();
    pulse_trig();
    repeat (9) @(posedge iclk_lte);
    #2;
    check_vec("t5_held", 64'(obuf_ready), 64'd1);
    check_vec("t5_nowr", 64'(q_addr.size()), 64'd0);
    pulse_done();
    check_vec("t5_release", 64'(obuf_ready), 64'd0);
    wait_ready("t5_ready", 100, 1'b0);
    check_vec("t5_count", 64'(q_addr.size()), 64'd8);
    check_vec("t5_addr0", 64'(q_addr[0]), 64'd0);
    check_vec("t5_mode", 64'(obuf_mode), 64'd1);
    check_vec("t5_len", 64'(obuf_len), 64'd8);
    pulse_done();

    // ---- asynchronous reset mid-IQ, then fresh telemetry frame
    pulse_trig();
    repeat (3) @(posedge iclk_lte);
    #2;
    check_vec("t6_running", 64'(owr_en), 64'd1);
    ireset = 1'b0;
    #1;
    check_vec("t6_rst_wr", {owr_en, owr_addr}, 64'd0);
    check_vec("t6_rst_data", 64'(owr_data), 64'd0);
    check_vec("t6_rst_buf", {obuf_ready, obuf_mode, obuf_len, oseq}, 64'd0);
    clear_log();
    ich_mask = 3'b111; ienable = 1'b1; ivalid = 1'b1;
    @(posedge iclk_lte); #2;
    ireset = 1'b1;
    wait_ready("t6_ready", 100, 1'b0);
    check_vec("t6_count", 64'(q_addr.size()), 64'd15);
    check_vec("t6_addr0", 64'(q_addr[0]), 64'd0);
    check_vec("t6_d0", 64'(q_data[0]), 64'h11111111);
    check_vec("t6_hdr4", 64'(q_data[4]), 64'h0AFA0000);
    check_vec("t6_mode", 64'(obuf_mode), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mqc_capture_seq.md
Name: mqc_capture_seq

Overview:
Parametrised capture sequencer for the LTE-clock side of the diagnostic buffer. In telemetry mode it builds frames from pCH_NUM service/link/power channels. Each enabled channel contributes pSEG_LEN data words, then one tagged header word. In IQ mode it captures pIQ_NUM sign-extended I/Q samples. It drives the write port of the dual-clock buffer_ram and holds each finished frame until the DSP-side reader acknowledges it.

Parameters:
pDAT_W, 32, buffer word width; must be >= 32.
pIQ_W, 12, I/Q sample width; must be <= pDAT_W/2.
pCH_NUM, 17, telemetry channel count; range 1..256.
pSEG_LEN, 1023, data words per channel per frame; >= 1.
pIQ_NUM, 200000, IQ words per capture; must be <= 2^pADDR_W.
pADDR_W, 18, buffer address width.
pMAGIC, 16'hAFA, header magic value.

Ports:
iclk_lte  in  1  capture clock.
ireset  in  1  reset, asynchronous, active-low.
ienable  in  1  telemetry auto-run enable.
ivalid  in  1  sample strobe; gates every write in both modes.
itrig_iq  in  1  IQ capture request, single-cycle pulse.
idata_re  in  pIQ_W  I sample, signed.
idata_im  in  pIQ_W  Q sample, signed.
ich_data  in  pCH_NUM*pDAT_W  flattened channels; channel k occupies bits [k*pDAT_W +: pDAT_W].
ich_mask  in  pCH_NUM  per-channel enable; sampled at frame start.
ird_done  in  1  reader-done pulse, already synchronised into iclk_lte.
owr_en  out  1  buffer write strobe.
owr_addr  out  pADDR_W  write address.
owr_data  out  pDAT_W  write data.
obuf_ready  out  1  frame complete, held until ird_done.
obuf_mode  out  1  0 = telemetry frame, 1 = IQ frame; valid while obuf_ready.
obuf_len  out  pADDR_W+1  words in the held frame.
oseq  out  8  telemetry frame sequence number.

Behaviour:
- Reset values: all outputs 0; state S_IDLE; internal mask latch 0; iq_pend 0.
- All outputs are registered. A write happens on the cycle after the accepted ivalid, with data sampled on that ivalid cycle.
- S_IDLE:
  - itrig_iq or iq_pend -> S_IQ; clears iq_pend.
  - Otherwise, if ienable = 1 and ich_mask != 0 -> S_TLM. Latches the mask, sets addr = 0, chan = first enabled channel, seg = 0.
  - If the mask is all zero, the block stays in S_IDLE.
- S_TLM, on each ivalid:
  - While seg < pSEG_LEN: write ich_data[chan]; seg++.
  - When seg == pSEG_LEN: write header {zeros, pMAGIC[15:0], oseq[7:0], chan[7:0]}; seg = 0; advance chan to the next enabled channel.
  - After the header of the last enabled channel: obuf_len = addr+1, obuf_mode = 0, obuf_ready = 1 -> S_READY.
  - addr increments on every write.
- S_IQ, on each ivalid: write {sext16(idata_re), sext16(idata_im)}, zero-extended to pDAT_W. After word pIQ_NUM: obuf_len = pIQ_NUM, obuf_mode = 1, obuf_ready = 1 -> S_READY.
- S_READY: no writes. ird_done clears obuf_ready -> S_IDLE on the next cycle. oseq increments (mod 256) only when a telemetry frame is released.
- Simultaneous events:
  - itrig_iq in S_TLM aborts the frame (no header is written, oseq is unchanged) -> S_IQ with addr = 0.
  - itrig_iq in S_IQ is ignored.
  - itrig_iq in S_READY sets iq_pend.
  - itrig_iq coinciding with ird_done: release, then S_IQ directly.
- ird_done outside S_READY is ignored.
- ienable dropping mid-frame: the current frame completes.
- ich_mask changes mid-frame take effect at the next frame.
- Reset mid-operation: immediate return to reset values. Any partial buffer contents are abandoned.

Decomposition:
- Package mqc_pkg holds:
  - state encoding S_IDLE/S_TLM/S_IQ/S_READY;
  - the header field layout, with the magic field at bits [31:16], sequence at [15:8] and channel at [7:0];
  - a function f_tlm_len(mask) computing the frame length.
- One sub-module, mqc_next_ch, is natural: a combinational priority finder returning the next set mask bit above the current index, plus a last flag.

Test Plan:
- Reset, pCH_NUM=3, pSEG_LEN=4, mask=3'b111, ivalid=1 -> 15 writes at addr 0..14; addr 4 = 0x0AFA0000, 9 = 0x0AFA0001, 14 = 0x0AFA0002; obuf_len=15, obuf_mode=0.
- Same setup with mask=3'b101 -> 10 writes; headers at addr 4 (ch 0) and 9 (ch 2); ird_done -> oseq=1; next frame header = 0x0AFA0100.
- pIQ_NUM=8, itrig_iq, re=-1, im=5, ivalid toggling 1/0 -> 8 writes of 0xFFFF0005 spaced 2 cycles apart; obuf_mode=1, obuf_len=8.
- itrig_iq at addr 6 of a telemetry frame -> IQ writes restart at addr 0; oseq unchanged; the final frame is IQ.
- itrig_iq in S_READY, then ird_done 10 cycles later -> obuf_ready falls; S_IQ is entered without a new trigger.
- ireset low mid-IQ -> all outputs 0 asynchronously; after release with ienable=1, a telemetry frame starts at addr 0.
